// File: rtl/affine_pkg.sv
// Shared widths, default AES affine constants and the GF(2) byte-affine helper
// used by the affine_out_pipe output stage.
package affine_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_LANES  = 16;
    localparam int MAX_SHARES = 4;
    localparam int MAX_PIPE   = 3;

    localparam logic [63:0] AES_FWD_MAT = 64'hF87C3E1F8FC7E3F1;
    localparam logic [7:0]  AES_FWD_CST = 8'h63;
    localparam logic [63:0] IDENT_MAT   = 64'h8040201008040201;

    // Row i of the matrix sits in mat[8i+7:8i]; output bit i is the parity of row_i & a.
    function automatic logic [7:0] affine_byte(
        input logic [63:0] mat,
        input logic [7:0]  cst,
        input logic [7:0]  a,
        input logic        add_const
    );
        logic [7:0] z;
        z = '0;
        for (int i = 0; i < 8; i++) begin
            z[i] = (^(mat[8*i +: 8] & a)) ^ (add_const & cst[i]);
        end
        return z;
    endfunction

endpackage

// File: rtl/affine_pipe_stage.sv
// One elastic valid/ready register slice; a full slice still accepts when its
// downstream takes the held word in the same cycle.
module affine_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);

    logic         valid_q, valid_d;
    logic [W-1:0] payload_q, payload_d;

    assign in_ready    = ~valid_q | out_ready;
    assign out_valid   = valid_q;
    assign out_payload = payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                payload_d = in_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/affine_out_pipe.sv
// Shared-domain output affine map Z = M*A ^ C (constant on share 0 only) followed
// by PIPE elastic register slices. Define AFFINE_PARITY_EN to add the out_par port.
module affine_out_pipe
    import affine_pkg::*;
#(
    parameter int          LANES  = 4,
    parameter int          SHARES = 3,
    parameter int          PIPE   = 2,
    parameter logic [63:0] MAT0   = AES_FWD_MAT,
    parameter logic [7:0]  CST0   = AES_FWD_CST,
    parameter logic [63:0] MAT1   = IDENT_MAT,
    parameter logic [7:0]  CST1   = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic [LANES*SHARES*8-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_mode,
`ifdef AFFINE_PARITY_EN
    output logic [LANES*SHARES-1:0]      out_par,
`endif
    output logic [LANES*SHARES*8-1:0]    out_data
);

    localparam int NB = LANES * SHARES;
    localparam int DW = NB * BYTE_W;
`ifdef AFFINE_PARITY_EN
    localparam int SW = DW + 1 + NB;
`else
    localparam int SW = DW + 1;
`endif

    if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
        $error("affine_out_pipe: LANES out of range 1..16");
    end
    if (SHARES < 1 || SHARES > MAX_SHARES) begin : g_bad_shares
        $error("affine_out_pipe: SHARES out of range 1..4");
    end
    if (PIPE < 1 || PIPE > MAX_PIPE) begin : g_bad_pipe
        $error("affine_out_pipe: PIPE out of range 1..3");
    end

    logic [63:0]   sel_mat;
    logic [7:0]    sel_cst;
    logic [DW-1:0] xf_data;
    logic [SW-1:0] stage_in;

    assign sel_mat = in_mode ? MAT1 : MAT0;
    assign sel_cst = in_mode ? CST1 : CST0;

    // Byte index gi maps to share (gi % SHARES); only share 0 absorbs the constant.
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign xf_data[gi*BYTE_W +: BYTE_W] =
            affine_byte(sel_mat, sel_cst, in_data[gi*BYTE_W +: BYTE_W], (gi % SHARES) == 0);
    end

`ifdef AFFINE_PARITY_EN
    logic [NB-1:0] xf_par;
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
        assign xf_par[gi] = ^xf_data[gi*BYTE_W +: BYTE_W];
    end
    assign stage_in = {xf_par, in_mode, xf_data};
`else
    assign stage_in = {in_mode, xf_data};
`endif

    logic [PIPE:0] valid_c;
    logic [PIPE:0] ready_c;
    logic [SW-1:0] payload_c [0:PIPE];

    assign valid_c[0]    = in_valid;
    assign payload_c[0]  = stage_in;
    assign in_ready      = ready_c[0];
    assign ready_c[PIPE] = out_ready;

    for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
        affine_pipe_stage #(.W(SW)) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (valid_c[gi]),
            .in_ready    (ready_c[gi]),
            .in_payload  (payload_c[gi]),
            .out_valid   (valid_c[gi+1]),
            .out_ready   (ready_c[gi+1]),
            .out_payload (payload_c[gi+1])
        );
    end

    assign out_valid = valid_c[PIPE];
    assign out_data  = payload_c[PIPE][DW-1:0];
    assign out_mode  = payload_c[PIPE][DW];
`ifdef AFFINE_PARITY_EN
    assign out_par   = payload_c[PIPE][DW+1 +: NB];
`endif

endmodule

// File: tb/tb_affine_out_pipe.sv
// Randomized self-checking bench for affine_out_pipe with a rotate-based AES
// affine reference model and an in-order expectation queue.
module tb_affine_out_pipe;

    localparam int LANES  = 4;
    localparam int SHARES = 3;
    localparam int PIPE   = 2;
    localparam int NB     = LANES * SHARES;
    localparam int DW     = NB * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_mode;
    logic [DW-1:0] out_data;
`ifdef AFFINE_PARITY_EN
    logic [NB-1:0] out_par;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          mode;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    affine_out_pipe #(.LANES(LANES), .SHARES(SHARES), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
`ifdef AFFINE_PARITY_EN
        .out_par   (out_par),
`endif
        .out_data  (out_data)
    );

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    // AES forward affine written as b ^ rotl1..4 ^ 0x63; mode 1 is identity.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] din, input logic mode);
        logic [DW-1:0] r;
        logic [7:0] b, y;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SHARES; s++) begin
                b = din[(l*SHARES+s)*8 +: 8];
                if (mode == 1'b0) begin
                    y = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4);
                    if (s == 0) y = y ^ 8'h63;
                end else begin
                    y = b;
                end
                r[(l*SHARES+s)*8 +: 8] = y;
            end
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] par_of(input logic [DW-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[i*8 +: 8];
        return p;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'($urandom);
        return d;
    endfunction

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_mode !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: out_valid=%b out_mode=%b in_ready=%b out_data=%h (want 0,0,1,0)",
                     out_valid, out_mode, in_ready, out_data);
        end
    endtask

    task automatic test_fwd_bytes();
        logic [7:0] bin [3];
        logic [7:0] bexp [3];
        logic [DW-1:0] want;
        int lat;
        bin[0] = 8'h00; bin[1] = 8'h01; bin[2] = 8'hCA;
        bexp[0] = 8'h63; bexp[1] = 8'h7C; bexp[2] = 8'hED;
        for (int t = 0; t < 3; t++) begin
            in_data = '0;
            want = '0;
            for (int l = 0; l < LANES; l++) begin
                in_data[(l*SHARES)*8 +: 8] = bin[t];
                want[(l*SHARES)*8 +: 8] = bexp[t];
            end
            in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                lat++;
                if (out_valid) break;
            end
            n_cmp++;
            if (lat !== PIPE) begin
                n_bad++;
                $display("FAIL fwd_latency: byte %h latency %0d want %0d", bin[t], lat, PIPE);
            end
            n_cmp++;
            if (out_data !== want || out_mode !== 1'b0) begin
                n_bad++;
                $display("FAIL fwd_byte: in %h out %h want %h mode %b", bin[t], out_data, want, out_mode);
            end
`ifdef AFFINE_PARITY_EN
            n_cmp++;
            if (out_par !== par_of(want)) begin
                n_bad++;
                $display("FAIL parity_byte: in %h par %b want %b", bin[t], out_par, par_of(want));
            end
`endif
            $display("fwd byte %h -> %h latency %0d", bin[t], out_data[7:0], lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_shares();
        logic [DW-1:0] din, want;
        logic [7:0] s1, s2, rec;
        int w;
        din = '0;
        for (int l = 0; l < LANES; l++) begin
            s1 = 8'($urandom); s2 = 8'($urandom);
            din[(l*SHARES+0)*8 +: 8] = 8'hCA ^ s1 ^ s2;
            din[(l*SHARES+1)*8 +: 8] = s1;
            din[(l*SHARES+2)*8 +: 8] = s2;
        end
        want = model(din, 1'b0);
        in_data = din; in_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (w < 10) begin
            @(negedge clk);
            w++;
            if (out_valid) break;
        end
        n_cmp++;
        if (!out_valid || out_data !== want) begin
            n_bad++;
            $display("FAIL shares_model: out %h want %h valid %b", out_data, want, out_valid);
        end
        for (int l = 0; l < LANES; l++) begin
            rec = out_data[(l*SHARES)*8 +: 8] ^ out_data[(l*SHARES+1)*8 +: 8] ^ out_data[(l*SHARES+2)*8 +: 8];
            n_cmp++;
            if (rec !== 8'hED) begin
                n_bad++;
                $display("FAIL shares_recombine: lane %0d got %h want ed", l, rec);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        logic [DW-1:0] din;
        int w;
        for (int l = 0; l < LANES; l++) begin
            din[(l*SHARES+0)*8 +: 8] = 8'h12;
            din[(l*SHARES+1)*8 +: 8] = 8'h34;
            din[(l*SHARES+2)*8 +: 8] = 8'h56;
        end
        in_data = din; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (w < 10) begin
            @(negedge clk);
            w++;
            if (out_valid) break;
        end
        n_cmp++;
        if (!out_valid || out_data !== din || out_mode !== 1'b1) begin
            n_bad++;
            $display("FAIL identity: out %h want %h mode %b", out_data, din, out_mode);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alt_mode_stream();
        exp_t e;
        int got = 0, sent = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid  = (c < 40) ? ($urandom_range(0, 9) < 8) : 1'b0;
            in_mode   = 1'(c);
            in_data   = rand_data();
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: unexpected output %h", out_data);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (out_data !== e.data || out_mode !== e.mode) begin
                        n_bad++;
                        $display("FAIL stream_data: out %h mode %b want %h mode %b",
                                 out_data, out_mode, e.data, e.mode);
                    end
`ifdef AFFINE_PARITY_EN
                    else if (out_par !== par_of(e.data)) begin
                        n_bad++;
                        $display("FAIL stream_par: par %b want %b", out_par, par_of(e.data));
                    end
`endif
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{model(in_data, in_mode), in_mode});
                sent++;
            end
            @(posedge clk); #1;
            if (c >= 40 && q.size() == 0) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (q.size() != 0 || got != sent) begin
            n_bad++;
            $display("FAIL stream_count: delivered %0d want %0d (left %0d)", got, sent, q.size());
        end
        $display("alternating stream: %0d transfers delivered", got);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int acc = 0, got = 0;
        logic [DW-1:0] held = '0;
        logic have = 1'b0, stable = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_mode = 1'($urandom); in_data = rand_data();
            @(negedge clk);
            if (out_valid) begin
                if (!have) begin held = out_data; have = 1'b1; end
                else if (out_data !== held) stable = 1'b0;
            end
            if (in_ready) begin
                acc++;
                q.push_back('{model(in_data, in_mode), in_mode});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc !== PIPE) begin
            n_bad++;
            $display("FAIL bp_accepted: accepted %0d want %0d", acc, PIPE);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_in_ready: in_ready %b want 0", in_ready);
        end
        n_cmp++;
        if (!(have && stable)) begin
            n_bad++;
            $display("FAIL bp_stable: held valid %b stable %b want 1 1", have, stable);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_extra: duplicate output %h", out_data);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (out_data !== e.data || out_mode !== e.mode) begin
                        n_bad++;
                        $display("FAIL bp_drain: out %h want %h", out_data, e.data);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (got !== PIPE || q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_count: drained %0d want %0d", got, PIPE);
        end
        $display("backpressure: accepted %0d drained %0d", acc, got);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_mode = 1'b1; in_data = rand_data();
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_mode !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: out_valid %b out_mode %b out_data %h want all 0",
                     out_valid, out_mode, out_data);
        end
        in_valid = 1'b0;
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        @(posedge clk); #1;
        test_fwd_bytes();
        test_shares();
        test_identity();
        test_alt_mode_stream();
        test_backpressure();
        test_async_reset();
        test_alt_mode_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
